// File: rtl/platformniostimer_mem_test_master.sv
// platformniostimer_mem_test_master: Avalon-MM fill/check initiator for the on-chip RAM.
// Define MEMTEST_LFSR_EN to use a Galois LFSR pattern instead of seed+i.
module platformniostimer_mem_test_master #(
    parameter int ADDR_W = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [31:0]       cmd_seed,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);
    localparam int RL = READ_LATENCY;
    localparam logic [RL-1:0] DRAIN_MASK = {RL{1'b1}} >> 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic              chk_after, cs_q, go, last, xfer;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len, rem;
    logic [31:0]       seed, pat;
    logic [RL-1:0]     vld;
    logic [31:0]       pexp [RL];
    logic [ADDR_W-1:0] padr [RL];

    function automatic logic [31:0] pat_init(input logic [31:0] s);
`ifdef MEMTEST_LFSR_EN
        return s == 32'd0 ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] pat_step(input logic [31:0] x);
`ifdef MEMTEST_LFSR_EN
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
`else
        return x + 32'd1;
`endif
    endfunction

    assign go             = start && !abort;
    assign last           = rem == (ADDR_W+1)'(1);
    assign xfer           = state == WRITE || state == READ;
    assign busy           = state != IDLE;
    assign done           = state == DONE && !abort;
    assign avm_chipselect = cs_q && !abort;
    assign avm_byteenable = {4{avm_chipselect}};
    assign avm_writedata  = pat;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = cmd_len == '0 ? DONE : (cmd_mode[0] ? READ : WRITE);
            WRITE:   if (last) state_n = chk_after ? READ : DONE;
            READ:    if (last) state_n = DRAIN;
            DRAIN:   if ((vld & DRAIN_MASK) == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_after      <= 1'b0;
            cs_q           <= 1'b0;
            base           <= '0;
            len            <= '0;
            rem            <= '0;
            seed           <= '0;
            pat            <= '0;
            vld            <= '0;
            err            <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_address    <= '0;
            avm_write      <= 1'b0;
            for (int j = 0; j < RL; j++) begin
                pexp[j] <= '0;
                padr[j] <= '0;
            end
        end else begin
            if (vld[RL-1] && !abort && avm_readdata != pexp[RL-1]) begin
                err       <= 1'b1;
                err_count <= err_count + {15'd0, err_count != 16'hFFFF};
                if (!err) first_err_addr <= padr[RL-1];
            end
            // expected word and address ride alongside each read until its data returns
            vld[0]  <= state == READ;
            pexp[0] <= pat;
            padr[0] <= avm_address;
            for (int j = 1; j < RL; j++) begin
                vld[j]  <= vld[j-1];
                pexp[j] <= pexp[j-1];
                padr[j] <= padr[j-1];
            end
            if (state == IDLE && go) begin
                chk_after      <= cmd_mode == 2'd2;
                base           <= cmd_base;
                len            <= cmd_len;
                rem            <= cmd_len;
                seed           <= pat_init(cmd_seed);
                pat            <= pat_init(cmd_seed);
                avm_address    <= cmd_base;
                cs_q           <= cmd_len != '0;
                avm_write      <= !cmd_mode[0] && cmd_len != '0;
                err            <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (xfer) begin
                if (!last) begin
                    avm_address <= avm_address + ADDR_W'(1);
                    rem         <= rem - (ADDR_W+1)'(1);
                    pat         <= pat_step(pat);
                end else if (state == WRITE && chk_after) begin
                    avm_address <= base;
                    rem         <= len;
                    pat         <= seed;
                    avm_write   <= 1'b0;
                end else begin
                    cs_q      <= 1'b0;
                    avm_write <= 1'b0;
                end
            end
            if (abort && state != IDLE) begin
                cs_q      <= 1'b0;
                avm_write <= 1'b0;
                vld       <= '0;
            end
        end
    end
endmodule

// File: doc/platformniostimer_mem_test_master.md
# platformniostimer_mem_test_master

Avalon-MM initiator that drives the single-port on-chip RAM slave (32-bit data, 13-bit word address, fixed read latency, no waitrequest) to fill a word range with a generated pattern and/or read it back and check it. It sits beside the Nios II data master on the RAM's slave port and is used for power-on memory test and scrub. The block reports a one-cycle `done` pulse, a sticky error flag, a saturating mismatch count and the first failing address.

## Interface
- `ADDR_W`, 13, word-address width; sets the range wrap modulus 2^ADDR_W.
- `READ_LATENCY`, 1, slave read latency in cycles; legal values 1 or 2.
- `clk`  in  1  clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  begin command; sampled only when `busy`=0.
- `abort`  in  1  stop the current command.
- `cmd_mode`  in  2  0=fill, 1=check, 2=fill-then-check, 3=reserved, treated as 1.
- `cmd_base`  in  ADDR_W  first word address.
- `cmd_len`  in  ADDR_W+1  word count, 0..2^ADDR_W.
- `cmd_seed`  in  32  pattern seed.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky mismatch flag.
- `err_count`  out  16  saturating mismatch count.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `avm_address`  out  ADDR_W  word address to the slave.
- `avm_byteenable`  out  4  constant 4'hF while `avm_chipselect`=1, else 0.
- `avm_chipselect`  out  1  transfer valid.
- `avm_write`  out  1  1=write, 0=read; qualified by chipselect.
- `avm_writedata`  out  32  pattern word.
- `avm_readdata`  in  32  slave read data, valid READ_LATENCY cycles after the read.

## Operation
- The FSM has five states: IDLE, WRITE, READ, DRAIN and DONE.
- **IDLE.** When `start`=1, the block latches the command, clears `err`, `err_count` and `first_err_addr`, and sets `busy`.
  - `cmd_len`=0 goes to DONE.
  - Mode 0 or 2 goes to WRITE.
  - Mode 1 or 3 goes to READ.
- **WRITE.** Issues one write per cycle at `base+i` for i=0..len-1.
  - Address arithmetic is modulo 2^ADDR_W, so the range wraps past the top address.
  - After the last write, mode 0 goes to DONE and mode 2 goes to READ with no bubble cycle.
- **READ.** Issues one read per cycle over the same range.
  - The expected word and its address travel through a READ_LATENCY-deep valid pipeline alongside each read.
  - After the last read, goes to DRAIN.
- **DRAIN.** Waits until the pipeline is empty, then goes to DONE.
- **Compare.** Runs on every pipeline entry that exits valid, including entries exiting during DRAIN.
  - On mismatch: set `err`, increment `err_count` (saturates at 16'hFFFF), and capture `first_err_addr` only when `err` was 0.
- **DONE.** Pulses `done` for one cycle, clears `busy` and returns to IDLE.
- **Pattern.** Word i = `cmd_seed` + i, modulo 2^32. The generator restarts from the seed at the start of the READ pass.
- **`abort`.** In any non-IDLE state, deasserts `avm_chipselect` in the same cycle (combinational gate) and goes to IDLE.
  - In-flight reads are discarded and not compared.
  - No `done` pulse; `busy`=0 the next cycle.
  - Error statistics are retained.
- **`start` and `abort` together in IDLE.** `abort` wins and the command is dropped.
- **`start` while `busy`.** Ignored.
- **`reset` mid-command.** Outputs return to reset values the next cycle and in-flight reads are discarded.

## Timing
- Reset values: every output is 0, including `avm_byteenable`. The FSM is in IDLE.
- All `avm_*` outputs are registered, except for the `abort` gate on chipselect.
- Define `start` sampled at edge 0. The first transfer is driven in cycle 1.
- Latencies for N≥1 words (RL = READ_LATENCY):
  - Fill: writes in cycles 1..N, `done` in cycle N+1.
  - Check: reads in cycles 1..N, last compare in cycle N+RL, `done` in cycle N+RL+1.
  - Fill-then-check: writes in 1..N, reads in N+1..2N, `done` in cycle 2N+RL+1.
- `cmd_len`=0: `done` in cycle 1 and no transfers.
- `avm_readdata` is sampled exactly RL cycles after the cycle in which its read is driven.

## Configuration
- Macro: `MEMTEST_LFSR_EN`.
- **Defined:** the pattern is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
  - It is loaded with `cmd_seed`; a seed of 0 is replaced by 1.
  - Word 0 is the seed, and the LFSR advances one step per word.
- **Undefined:** the incrementing `seed+i` pattern is used and no LFSR logic is synthesized.

## Test plan
- **Fill then check, clean memory.** Mode 2, base 0x0010, len 4, seed 0xA5A50000 (no LFSR).
  - Writes 0xA5A50000..0xA5A50003 to 0x10..0x13 in cycles 1..4.
  - Reads in cycles 5..8.
  - `done` in cycle 10 (RL=1), `err`=0.
- **Single corrupted word.** Preload the model with the mode-2 pattern, corrupt address 0x12, then run mode 1 with the same command.
  - `err`=1, `err_count`=1, `first_err_addr`=0x0012.
- **Address wrap.** Mode 0, base 0x1FFE, len 4.
  - Writes land on addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
  - `done` in cycle 5.
- **Zero length.** `cmd_len`=0.
  - `done` in cycle 1 and `avm_chipselect` is never asserted.
- **Abort and reset mid-check.** Mode 1, len 100, `abort` in cycle 20.
  - chipselect drops in cycle 20 with no `done`, `busy`=0 in cycle 21, and a new `start` is accepted in cycle 21.
  - Repeat with `reset` in cycle 20: all outputs are 0 in cycle 21.
- **LFSR pattern (`MEMTEST_LFSR_EN`).**
  - Seed 0: the first written word is 0x00000001.
  - Seed 1, len 3, mode 2: all three compares match and `err`=0.
  - RL=2 build: `done` in cycle 2N+3 for mode 2.
